// File: rtl/fc_acc_buffer_nbank_pkg.sv
// Shared types and helpers for the N-bank FC accumulation buffer.
package fc_buf_pkg;

  typedef enum logic [1:0] {BANK_FREE, BANK_ACC, BANK_FULL} bank_state_e;

  // Pointer width; a 2-bank buffer still needs one bit.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Increment that wraps at n, so n need not be a power of two.
  function automatic int wrap_inc(input int p, input int n);
    return (p >= n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/fc_acc_buffer_nbank_lane.sv
// One accumulator lane: unsigned add of an addend into a running sum, clamping or wrapping on carry.
module fc_acc_lane #(
  parameter int IWID = 8,
  parameter int OWID = 12,
  parameter int SAT  = 1
) (
  input  logic [IWID-1:0] i_add,
  input  logic [OWID-1:0] i_acc,
  output logic [OWID-1:0] o_sum,
  output logic            o_carry
);

  logic [OWID:0] w_s;

  assign w_s     = {1'b0, i_acc} + {{(OWID + 1 - IWID){1'b0}}, i_add};
  assign o_carry = w_s[OWID];
  assign o_sum   = ((SAT != 0) && w_s[OWID]) ? {OWID{1'b1}} : w_s[OWID-1:0];

endmodule

// File: rtl/fc_acc_buffer_nbank.sv
// Rotating N-bank accumulation buffer: one bank accumulates while closed banks drain in order.
// Closed banks are presented straight from registers; the input stalls only on a close into a full ring.
module fc_acc_buffer_nbank
  import fc_buf_pkg::*;
#(
  parameter int IDIM  = 1,
  parameter int IWID  = $clog2(110*32) + 1,
  parameter int OWID  = $clog2(110*32) + 1 + 10,
  parameter int NBANK = 2,
  parameter int SAT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iValid,
  output logic                       iReady,
  input  logic                       iLast,
  input  logic                       iClear,
  input  logic [IDIM*IWID-1:0]       iData,
  output logic                       oValid,
  input  logic                       oReady,
  output logic [IDIM*OWID-1:0]       oData,
  output logic                       oOvf,
  output logic [$clog2(NBANK+1)-1:0] oLevel
);

  localparam int PW = ptr_w(NBANK);
  localparam int LW = $clog2(NBANK + 1);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [LW-1:0] cnt_t;

  ptr_t                 r_wptr;
  ptr_t                 r_rptr;
  cnt_t                 r_fcnt;
  logic [IDIM*OWID-1:0] r_bank [NBANK];
  logic [NBANK-1:0]     r_ovf;
  logic [NBANK-1:0]     r_full;

  logic [IDIM*OWID-1:0] w_acc;
  logic [IDIM*OWID-1:0] w_sum;
  logic [IDIM-1:0]      w_carry;
  logic                 w_accept;
  logic                 w_close;
  logic                 w_pop;
  ptr_t                 w_wnext;
  ptr_t                 w_rnext;
  bank_state_e          w_state [NBANK];

  // iReady looks only at the current fill count, never at oReady.
  assign iReady   = ~(iLast & (r_fcnt == cnt_t'(NBANK - 1)));
  assign w_accept = iValid & iReady;
  assign w_close  = w_accept & iLast & ~iClear;
  assign w_pop    = oValid & oReady;
  assign w_wnext  = ptr_t'(wrap_inc(int'(r_wptr), NBANK));
  assign w_rnext  = ptr_t'(wrap_inc(int'(r_rptr), NBANK));
  assign w_acc    = r_bank[r_wptr];

  assign oValid = (r_fcnt != '0);
  assign oData  = r_bank[r_rptr];
  assign oOvf   = r_ovf[r_rptr];
  assign oLevel = r_fcnt;

  for (genvar l = 0; l < IDIM; l++) begin : g_lane
    fc_acc_lane #(.IWID(IWID), .OWID(OWID), .SAT(SAT)) u_lane (
      .i_add   (iData[l*IWID +: IWID]),
      .i_acc   (w_acc[l*OWID +: OWID]),
      .o_sum   (w_sum[l*OWID +: OWID]),
      .o_carry (w_carry[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBANK; b++) r_bank[b] <= '0;
      r_ovf  <= '0;
      r_full <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (iClear) begin
        r_bank[r_wptr] <= '0;
        r_ovf[r_wptr]  <= 1'b0;
      end else if (w_accept) begin
        r_bank[r_wptr] <= w_sum;
        r_ovf[r_wptr]  <= r_ovf[r_wptr] | (|w_carry);
        if (iLast) begin
          // The bank we move into is wiped here so it never carries stale sums.
          r_full[r_wptr]  <= 1'b1;
          r_wptr          <= w_wnext;
          r_bank[w_wnext] <= '0;
          r_ovf[w_wnext]  <= 1'b0;
        end
      end
      if (w_pop) begin
        r_rptr         <= w_rnext;
        r_full[r_rptr] <= 1'b0;
      end
      case ({w_close, w_pop})
        2'b10:   r_fcnt <= r_fcnt + cnt_t'(1);
        2'b01:   r_fcnt <= r_fcnt - cnt_t'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      w_state[b] = BANK_FREE;
      if (r_full[b])               w_state[b] = BANK_FULL;
      else if (ptr_t'(b) == r_wptr) w_state[b] = BANK_ACC;
    end
  end

  a_wbank_acc: assert property (@(posedge clk) disable iff (rst)
    w_state[r_wptr] == BANK_ACC);
  a_rbank_full: assert property (@(posedge clk) disable iff (rst)
    oValid == (w_state[r_rptr] == BANK_FULL));

endmodule
